// File: rtl/jstk_pkg.sv
// Shared types and constants for the PmodJSTK poller: FSM states, frame length, LED command prefix.
package jstk_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_GAP,
    ST_DONE
  } jstk_state_e;

  localparam int unsigned NUM_BYTES  = 5;
  localparam logic [5:0]  LED_PREFIX = 6'b100000;

  function automatic logic [9:0] axis_decode(input logic [7:0] lo, input logic [1:0] hi);
    return {hi, lo};
  endfunction

endpackage

// File: rtl/spi_byte_xfer.sv
// SPI mode-0 master shifting one byte MSB first; SCLK half-period is SCLK_DIV clk cycles.
module spi_byte_xfer #(
  parameter int SCLK_DIV = 50
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_i,
  input  logic [7:0] tx_byte_i,
  input  logic       miso_i,
  output logic       sclk_o,
  output logic       mosi_o,
  output logic [7:0] rx_byte_o,
  output logic       done_o
);

  localparam int unsigned DIV_W = $clog2(SCLK_DIV + 1);

  logic             busy_q;
  logic [DIV_W-1:0] div_q;
  logic [2:0]       bit_q;
  logic [7:0]       tx_q;
  logic [7:0]       rx_q;
  logic             sclk_q;
  logic             done_q;

  // MOSI is the head of the transmit shifter, so it only moves when tx_q shifts on a falling edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      div_q  <= '0;
      bit_q  <= '0;
      tx_q   <= '0;
      rx_q   <= '0;
      sclk_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (!busy_q) begin
        if (start_i) begin
          busy_q <= 1'b1;
          tx_q   <= tx_byte_i;
          div_q  <= '0;
          bit_q  <= '0;
          sclk_q <= 1'b0;
        end
      end else if (div_q == DIV_W'(SCLK_DIV - 1)) begin
        div_q <= '0;
        if (!sclk_q) begin
          sclk_q <= 1'b1;
          rx_q   <= {rx_q[6:0], miso_i};
        end else begin
          sclk_q <= 1'b0;
          if (bit_q == 3'd7) begin
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end else begin
            bit_q <= bit_q + 3'd1;
            tx_q  <= {tx_q[6:0], 1'b0};
          end
        end
      end else begin
        div_q <= div_q + 1'b1;
      end
    end
  end

  assign sclk_o    = sclk_q;
  assign mosi_o    = tx_q[7];
  assign rx_byte_o = rx_q;
  assign done_o    = done_q;

endmodule

// File: rtl/joystick_dir.sv
// PmodJSTK poller: reads a 5-byte frame periodically and decodes axes, buttons and hysteretic directions.
// Define JSTK_BTN_DEBOUNCE_EN to require two matching frames before btn changes.
module joystick_dir
  import jstk_pkg::*;
#(
  parameter int CLK_HZ   = 100000000,
  parameter int POLL_HZ  = 100,
  parameter int SCLK_DIV = 50,
  parameter int GAP_CYC  = 1000,
  parameter int DEAD_LO  = 300,
  parameter int DEAD_HI  = 700,
  parameter int HYST     = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       MISO,
  output logic       SS,
  output logic       SCLK,
  output logic       MOSI,
  input  logic [1:0] led_cmd,
  output logic [9:0] x_pos,
  output logic [9:0] y_pos,
  output logic [2:0] btn,
  output logic       left,
  output logic       right,
  output logic       up,
  output logic       down,
  output logic       frame_vld
);

  localparam int unsigned POLL_PERIOD = CLK_HZ / POLL_HZ;
  localparam int unsigned POLL_W      = $clog2(POLL_PERIOD + 1);
  localparam int unsigned GAP_W       = $clog2(GAP_CYC + 1);
  localparam logic [10:0] LO_SET      = 11'(DEAD_LO);
  localparam logic [10:0] LO_REL      = 11'(DEAD_LO + HYST);
  localparam logic [10:0] HI_SET      = 11'(DEAD_HI);
  localparam logic [10:0] HI_REL      = 11'(DEAD_HI - HYST);

  // Overlapping release bands would let opposite directions coexist
  if (DEAD_LO + HYST >= DEAD_HI - HYST) begin : g_bad_deadzone
    $error("joystick_dir: DEAD_LO + HYST must be below DEAD_HI - HYST");
  end

  logic [POLL_W-1:0] poll_q;
  logic              frame_start;

  assign frame_start = (poll_q == POLL_W'(POLL_PERIOD - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      poll_q <= '0;
    end else begin
      poll_q <= frame_start ? '0 : poll_q + 1'b1;
    end
  end

  jstk_state_e      state_q;
  logic             ss_q;
  logic [GAP_W-1:0] gap_q;
  logic [2:0]       byte_q;
  logic [1:0]       led_q;
  logic             xfer_start_q;
  logic [7:0]       xl_q, yl_q;
  logic [1:0]       xh_q, yh_q;
  logic [2:0]       braw_q;
  logic [9:0]       x_q, y_q;
  logic [2:0]       btn_q;
  logic             left_q, right_q, up_q, down_q;
  logic             vld_q;
`ifdef JSTK_BTN_DEBOUNCE_EN
  logic [2:0]       bprev_q;
`endif

  logic [7:0] tx_byte;
  logic [7:0] rx_byte;
  logic       xfer_done;

  assign tx_byte = (byte_q == 3'd0) ? {LED_PREFIX, led_q} : 8'h00;

  spi_byte_xfer #(
    .SCLK_DIV(SCLK_DIV)
  ) u_xfer (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_i   (xfer_start_q),
    .tx_byte_i (tx_byte),
    .miso_i    (MISO),
    .sclk_o    (SCLK),
    .mosi_o    (MOSI),
    .rx_byte_o (rx_byte),
    .done_o    (xfer_done)
  );

  logic [9:0]  x_new, y_new;
  logic [10:0] xw, yw;
  logic        left_d, right_d, up_d, down_d;

  assign x_new = axis_decode(xl_q, xh_q);
  assign y_new = axis_decode(yl_q, yh_q);
  assign xw    = {1'b0, x_new};
  assign yw    = {1'b0, y_new};

  // Each direction sets outside the deadzone and holds until the value clears the hysteresis band
  always_comb begin
    left_d  = left_q;
    right_d = right_q;
    down_d  = down_q;
    up_d    = up_q;
    if (xw < LO_SET)       left_d  = 1'b1;
    else if (xw >= LO_REL) left_d  = 1'b0;
    if (xw > HI_SET)       right_d = 1'b1;
    else if (xw <= HI_REL) right_d = 1'b0;
    if (yw < LO_SET)       down_d  = 1'b1;
    else if (yw >= LO_REL) down_d  = 1'b0;
    if (yw > HI_SET)       up_d    = 1'b1;
    else if (yw <= HI_REL) up_d    = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      ss_q         <= 1'b1;
      gap_q        <= '0;
      byte_q       <= '0;
      led_q        <= '0;
      xfer_start_q <= 1'b0;
      xl_q         <= '0;
      xh_q         <= '0;
      yl_q         <= '0;
      yh_q         <= '0;
      braw_q       <= '0;
      x_q          <= '0;
      y_q          <= '0;
      btn_q        <= '0;
      left_q       <= 1'b0;
      right_q      <= 1'b0;
      up_q         <= 1'b0;
      down_q       <= 1'b0;
      vld_q        <= 1'b0;
`ifdef JSTK_BTN_DEBOUNCE_EN
      bprev_q      <= '0;
`endif
    end else begin
      xfer_start_q <= 1'b0;
      vld_q        <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (frame_start) begin
            state_q <= ST_SETUP;
            ss_q    <= 1'b0;
            gap_q   <= '0;
            byte_q  <= '0;
            led_q   <= led_cmd;
          end
        end
        ST_SETUP, ST_GAP: begin
          if (gap_q == GAP_W'(GAP_CYC - 1)) begin
            gap_q        <= '0;
            xfer_start_q <= 1'b1;
            state_q      <= ST_SHIFT;
          end else begin
            gap_q <= gap_q + 1'b1;
          end
        end
        ST_SHIFT: begin
          if (xfer_done) begin
            case (byte_q)
              3'd0:    xl_q   <= rx_byte;
              3'd1:    xh_q   <= rx_byte[1:0];
              3'd2:    yl_q   <= rx_byte;
              3'd3:    yh_q   <= rx_byte[1:0];
              default: braw_q <= rx_byte[2:0];
            endcase
            if (byte_q == 3'(NUM_BYTES - 1)) begin
              state_q <= ST_DONE;
              ss_q    <= 1'b1;
            end else begin
              byte_q  <= byte_q + 3'd1;
              state_q <= ST_GAP;
            end
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          x_q     <= x_new;
          y_q     <= y_new;
          left_q  <= left_d;
          right_q <= right_d;
          up_q    <= up_d;
          down_q  <= down_d;
          vld_q   <= 1'b1;
`ifdef JSTK_BTN_DEBOUNCE_EN
          bprev_q <= braw_q;
          if (braw_q == bprev_q) btn_q <= braw_q;
`else
          btn_q   <= braw_q;
`endif
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign SS        = ss_q;
  assign x_pos     = x_q;
  assign y_pos     = y_q;
  assign btn       = btn_q;
  assign left      = left_q;
  assign right     = right_q;
  assign up        = up_q;
  assign down      = down_q;
  assign frame_vld = vld_q;

endmodule
